// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO with registered or first-word-fall-through read and registered status flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_v2 #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned UPP_TH = 4,
  parameter int unsigned LOW_TH = 2,
  parameter int unsigned FWFT   = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                       i_clr_err,
  output logic                       o_overflow,
  output logic                       o_underflow,
`endif
  input  logic                       i_wren,
  input  logic [DATA_W-1:0]          i_wrdata,
  input  logic                       i_rden,
  output logic [DATA_W-1:0]          o_rddata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_alm_full,
  output logic                       o_alm_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW:0] FullLvl    = CW'(DEPTH);
  localparam logic [AW:0] AlmFullLvl = CW'(DEPTH - UPP_TH);
  localparam logic [AW:0] AlmEmptyLvl = CW'(LOW_TH);

  typedef enum logic {StEmpty, StValid} fwft_st_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [AW:0]       mem_cnt;
  logic [DATA_W-1:0] rddata_q, rddata_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              alm_full_q, alm_full_d;
  logic              alm_empty_q, alm_empty_d;
  fwft_st_e          state_q, state_d;

  logic wr_acc, rd_acc, mem_rd, mem_nonempty;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
`endif

  always_comb begin
    wr_acc       = i_wren & ~full_q;
    rd_acc       = i_rden & ~empty_q;
    // Pointers carry one extra bit so their difference spans 0..DEPTH.
    mem_cnt      = wr_ptr_q - rd_ptr_q;
    mem_nonempty = (mem_cnt != '0);

    if (FWFT != 0) begin
      mem_rd = mem_nonempty & ((state_q == StEmpty) | rd_acc);
    end else begin
      mem_rd = rd_acc;
    end

    wr_ptr_d = wr_ptr_q + CW'(wr_acc);
    rd_ptr_d = rd_ptr_q + CW'(mem_rd);
    rddata_d = mem_rd ? mem_q[rd_ptr_q[AW-1:0]] : rddata_q;

    state_d = state_q;
    if (FWFT != 0) begin
      if (mem_rd) begin
        state_d = StValid;
      end else if (rd_acc) begin
        state_d = StEmpty;
      end
    end else begin
      state_d = StEmpty;
    end

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d      = (count_d == FullLvl);
    alm_full_d  = (count_d >= AlmFullLvl);
    alm_empty_d = (count_d <= AlmEmptyLvl);
    if (FWFT != 0) begin
      empty_d = (state_d == StEmpty);
    end else begin
      empty_d = (count_d == '0);
    end

`ifdef FIFO_ERR_FLAGS_EN
    // A new error in the same cycle as a clear wins.
    ovf_d = (i_wren & full_q)  | (ovf_q & ~i_clr_err);
    udf_d = (i_rden & empty_q) | (udf_q & ~i_clr_err);
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rstn) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rddata_q    <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      alm_full_q  <= 1'b0;
      alm_empty_q <= 1'b1;
      state_q     <= StEmpty;
`ifdef FIFO_ERR_FLAGS_EN
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rddata_q    <= rddata_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      alm_full_q  <= alm_full_d;
      alm_empty_q <= alm_empty_d;
      state_q     <= state_d;
`ifdef FIFO_ERR_FLAGS_EN
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
`endif
    end
  end

  assign o_rddata    = rddata_q;
  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_alm_full  = alm_full_q;
  assign o_alm_empty = alm_empty_q;
  assign o_count     = count_q;
`ifdef FIFO_ERR_FLAGS_EN
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2: one registered-read and one FWFT instance, DEPTH=16, DATA_W=8.
// Error-flag checks are compiled only when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wren0, rden0, wren1, rden1;
  logic [7:0] wd0, wd1, rd0, rd1;
  logic       full0, empty0, afull0, aempty0;
  logic       full1, empty1, afull1, aempty1;
  logic [4:0] cnt0, cnt1;
`ifdef FIFO_ERR_FLAGS_EN
  logic       clr0, clr1, ovf0, udf0, ovf1, udf1;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  sync_fifo_v2 #(.DATA_W(8), .DEPTH(16), .UPP_TH(4), .LOW_TH(2), .FWFT(0)) u_dut0 (
    .clk        (clk),
    .rstn       (rst),
`ifdef FIFO_ERR_FLAGS_EN
    .i_clr_err  (clr0),
    .o_overflow (ovf0),
    .o_underflow(udf0),
`endif
    .i_wren     (wren0),
    .i_wrdata   (wd0),
    .i_rden     (rden0),
    .o_rddata   (rd0),
    .o_full     (full0),
    .o_empty    (empty0),
    .o_alm_full (afull0),
    .o_alm_empty(aempty0),
    .o_count    (cnt0)
  );

  sync_fifo_v2 #(.DATA_W(8), .DEPTH(16), .UPP_TH(4), .LOW_TH(2), .FWFT(1)) u_dut1 (
    .clk        (clk),
    .rstn       (rst),
`ifdef FIFO_ERR_FLAGS_EN
    .i_clr_err  (clr1),
    .o_overflow (ovf1),
    .o_underflow(udf1),
`endif
    .i_wren     (wren1),
    .i_wrdata   (wd1),
    .i_rden     (rden1),
    .o_rddata   (rd1),
    .o_full     (full1),
    .o_empty    (empty1),
    .o_alm_full (afull1),
    .o_alm_empty(aempty1),
    .o_count    (cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wren0 = 1'b0; rden0 = 1'b0; wd0 = '0;
    wren1 = 1'b0; rden1 = 1'b0; wd1 = '0;
`ifdef FIFO_ERR_FLAGS_EN
    clr0 = 1'b0; clr1 = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Reset state, both instances
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_empty0", 32'(empty0), 1);
    chk("rst_aempty0", 32'(aempty0), 1);
    chk("rst_full0", 32'(full0), 0);
    chk("rst_afull0", 32'(afull0), 0);
    chk("rst_rd0", 32'(rd0), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    chk("rst_empty1", 32'(empty1), 1);

    // Fill 16 words
    for (int i = 0; i < 16; i++) begin
      wren0 = 1'b1; wd0 = 8'(i);
      tick();
      chk("fill_cnt", 32'(cnt0), 32'(i + 1));
      chk("fill_afull", 32'(afull0), 32'((i + 1) >= 12));
      chk("fill_full", 32'(full0), 32'((i + 1) == 16));
      chk("fill_aempty", 32'(aempty0), 32'((i + 1) <= 2));
    end
    wd0 = 8'h10;
    tick();
    wren0 = 1'b0;
    chk("ovf_cnt", 32'(cnt0), 16);
    chk("ovf_full", 32'(full0), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 32'(ovf0), 1);
`endif

    // Drain 16 words
    for (int i = 0; i < 16; i++) begin
      rden0 = 1'b1;
      tick();
      chk("drain_data", 32'(rd0), 32'(i));
      chk("drain_cnt", 32'(cnt0), 32'(15 - i));
      chk("drain_aempty", 32'(aempty0), 32'((15 - i) <= 2));
      chk("drain_empty", 32'(empty0), 32'(i == 15));
    end
    tick();
    rden0 = 1'b0;
    chk("udf_hold", 32'(rd0), 32'h0F);
    chk("udf_cnt", 32'(cnt0), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_flag", 32'(udf0), 1);
    clr0 = 1'b1; rden0 = 1'b1;
    tick();
    rden0 = 1'b0;
    chk("clr_prio_udf", 32'(udf0), 1);
    chk("clr_prio_ovf", 32'(ovf0), 0);
    tick();
    clr0 = 1'b0;
    chk("clr_udf", 32'(udf0), 0);
`endif

    // Fill to 8, then streaming read+write across pointer wrap
    for (int i = 0; i < 8; i++) begin
      wren0 = 1'b1; wd0 = 8'(8'h20 + i);
      tick();
    end
    chk("half_cnt", 32'(cnt0), 8);
    for (int i = 0; i < 40; i++) begin
      wren0 = 1'b1; rden0 = 1'b1; wd0 = 8'(8'h28 + i);
      tick();
      chk("stream_data", 32'(rd0), 32'(8'h20 + i));
      chk("stream_cnt", 32'(cnt0), 8);
    end
    rden0 = 1'b0;

    // Top up to full, then read+write while full
    for (int i = 0; i < 8; i++) begin
      wren0 = 1'b1; wd0 = 8'(8'h50 + i);
      tick();
    end
    chk("top_full", 32'(full0), 1);
    wren0 = 1'b1; rden0 = 1'b1; wd0 = 8'hEE;
    tick();
    wren0 = 1'b0; rden0 = 1'b0;
    chk("fullrw_cnt", 32'(cnt0), 15);
    chk("fullrw_data", 32'(rd0), 32'h48);
    chk("fullrw_full", 32'(full0), 0);
    chk("fullrw_afull", 32'(afull0), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("fullrw_ovf", 32'(ovf0), 1);
`endif

    // Reset mid-operation with count 9 and a write pending
    for (int i = 0; i < 6; i++) begin
      rden0 = 1'b1;
      tick();
    end
    rden0 = 1'b0;
    chk("pre_rst_cnt", 32'(cnt0), 9);
    rst = 1'b1; wren0 = 1'b1; wd0 = 8'h99;
    tick();
    rst = 1'b0; wren0 = 1'b0;
    chk("mrst_cnt", 32'(cnt0), 0);
    chk("mrst_empty", 32'(empty0), 1);
    chk("mrst_aempty", 32'(aempty0), 1);
    chk("mrst_full", 32'(full0), 0);
    chk("mrst_afull", 32'(afull0), 0);
    chk("mrst_rd", 32'(rd0), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mrst_ovf", 32'(ovf0), 0);
    chk("mrst_udf", 32'(udf0), 0);
`endif
    wren0 = 1'b1; wd0 = 8'h77;
    tick();
    wren0 = 1'b0; rden0 = 1'b1;
    tick();
    rden0 = 1'b0;
    chk("post_rst_data", 32'(rd0), 32'h77);
    chk("post_rst_empty", 32'(empty0), 1);

    // FWFT: single word latency
    wren1 = 1'b1; wd1 = 8'hA5;
    tick();
    wren1 = 1'b0;
    chk("fw_a5_cnt1", 32'(cnt1), 1);
    chk("fw_a5_empty1", 32'(empty1), 1);
    tick();
    chk("fw_a5_data", 32'(rd1), 32'hA5);
    chk("fw_a5_empty2", 32'(empty1), 0);
    chk("fw_a5_cnt2", 32'(cnt1), 1);
    rden1 = 1'b1;
    tick();
    rden1 = 1'b0;
    chk("fw_pop_empty", 32'(empty1), 1);
    chk("fw_pop_cnt", 32'(cnt1), 0);

    // FWFT: three words, pop back-to-back
    for (int i = 0; i < 3; i++) begin
      wren1 = 1'b1; wd1 = 8'(8'h11 * (i + 1));
      tick();
    end
    wren1 = 1'b0;
    tick();
    chk("fw3_head", 32'(rd1), 32'h11);
    chk("fw3_cnt", 32'(cnt1), 3);
    for (int i = 0; i < 3; i++) begin
      rden1 = 1'b1;
      tick();
      chk("fw3_cnt_pop", 32'(cnt1), 32'(2 - i));
      chk("fw3_empty_pop", 32'(empty1), 32'(i == 2));
      if (i < 2) chk("fw3_data_pop", 32'(rd1), 32'(8'h11 * (i + 2)));
    end
    rden1 = 1'b0;

    // FWFT: fill to 16 including output register, then drain
    for (int i = 0; i < 16; i++) begin
      wren1 = 1'b1; wd1 = 8'(8'h80 + i);
      tick();
    end
    wd1 = 8'hFF;
    tick();
    wren1 = 1'b0;
    chk("fwfull_cnt", 32'(cnt1), 16);
    chk("fwfull_full", 32'(full1), 1);
    chk("fwfull_head", 32'(rd1), 32'h80);
`ifdef FIFO_ERR_FLAGS_EN
    chk("fwfull_ovf", 32'(ovf1), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      rden1 = 1'b1;
      tick();
      chk("fwdrain_cnt", 32'(cnt1), 32'(15 - i));
      chk("fwdrain_empty", 32'(empty1), 32'(i == 15));
      if (i < 15) chk("fwdrain_data", 32'(rd1), 32'(8'h81 + i));
    end
    rden1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_v2.md
SYNC_FIFO_V2 -- requirements
Module: sync_fifo_v2

Interface
REQ-001 SHALL have parameter DATA_W, default 128, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, storage capacity in words; power of two, >= 4.
REQ-003 SHALL have parameter UPP_TH, default 4, free-entry threshold for almost-full.
REQ-004 SHALL have parameter LOW_TH, default 2, occupancy threshold for almost-empty.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rstn  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_wren  input  1  write request.
REQ-009 SHALL have port i_wrdata  input  DATA_W  write data.
REQ-010 SHALL have port i_rden  input  1  read request (pop).
REQ-011 SHALL have port o_rddata  output  DATA_W  read data.
REQ-012 SHALL have ports o_full, o_empty, o_alm_full, o_alm_empty  output  1 each  status flags.
REQ-013 SHALL have port o_count  output  $clog2(DEPTH)+1  words currently held.
REQ-014 SHALL have ports o_overflow, o_underflow  output  1 each, and i_clr_err  input  1  (present only with FIFO_ERR_FLAGS_EN).

Function
REQ-015 Write accepted iff i_wren=1 and o_full=0; rejected write SHALL change no state, even if a read occurs the same cycle.
REQ-016 Read accepted iff i_rden=1 and o_empty=0; rejected read SHALL change no state.
REQ-017 Simultaneous accepted read and write SHALL leave o_count unchanged and preserve order.
REQ-018 o_count SHALL update on the edge of the accepted operation; range 0..DEPTH, covering every stored word (including the FWFT output register).
REQ-019 o_full = (o_count == DEPTH); o_alm_full = (o_count >= DEPTH-UPP_TH); o_alm_empty = (o_count <= LOW_TH); all registered, consistent with o_count in the same cycle.
REQ-020 Read/write pointers SHALL wrap from DEPTH-1 to 0 without data loss or flag glitch.
REQ-021 FWFT=0: o_empty = (o_count == 0); o_rddata SHALL present the popped word in the cycle after the accepting edge and hold it until the next accepted read.
REQ-022 FWFT=1: o_empty=0 iff o_rddata holds a valid head word; an accepted read SHALL present the next word (or assert o_empty) after the same edge.
REQ-023 FWFT=1: a word written into an empty FIFO SHALL appear on o_rddata with o_empty=0 after the second rising edge following the write; o_count SHALL reach 1 after the first.
REQ-024 FWFT=1: internal prefetch SHALL be a 2-state machine (EMPTY, VALID) driving the output register; prefetch SHALL occur whenever memory is non-empty and the output register is empty or being popped.
REQ-025 Data SHALL be returned in write order, bit-exact.

Reset
REQ-026 When rstn=1 at a rising edge: pointers and o_count = 0, o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata = 0, error flags = 0, FWFT state = EMPTY.
REQ-027 Reset SHALL override simultaneous i_wren/i_rden; stored contents are discarded mid-operation.
REQ-028 Memory array SHALL NOT require reset.

Configuration
REQ-029 Macro FIFO_ERR_FLAGS_EN defined: o_overflow set sticky on any rejected write (i_wren=1, o_full=1); o_underflow set sticky on any rejected read (i_rden=1, o_empty=1); both cleared when i_clr_err=1 at an edge, a simultaneous set taking priority over the clear.
REQ-030 Macro FIFO_ERR_FLAGS_EN undefined: o_overflow, o_underflow, i_clr_err and their logic SHALL be absent; all other behaviour identical.

Verification (DEPTH=16, UPP_TH=4, LOW_TH=2, DATA_W=8)
REQ-031 FWFT=0: write 16 words 0x00..0x0F -> o_full=1, o_count=16; o_alm_full rises when o_count reaches 12; 17th write rejected, o_overflow=1 (macro on).
REQ-032 FWFT=0: read 16 words -> 0x00..0x0F each 1 cycle after its i_rden; o_alm_empty rises at o_count=2; o_empty=1 at 0; extra read -> o_underflow=1, o_rddata holds 0x0F.
REQ-033 Fill to 8, then 40 cycles of simultaneous read+write -> o_count stays 8, pointers wrap, output sequence continuous and in order.
REQ-034 FWFT=1: write 0xA5 into empty FIFO -> o_count=1 after first edge, o_rddata=0xA5 and o_empty=0 after second; pop -> o_empty=1 next cycle.
REQ-035 Full FIFO, simultaneous read+write -> write rejected, read accepted, o_count=15.
REQ-036 Assert rstn for one cycle with o_count=9 and i_wren=1 -> all outputs at reset values after that edge; i_clr_err=1 clears sticky flags.
